// File: rtl/alu_types_pkg.sv
// Shared types for the decode stage: ALU operation encoding.
package alu_types_pkg;

   typedef enum logic [3:0] {
      ALU_OP_ADD  = 4'd0,
      ALU_OP_SUB  = 4'd1,
      ALU_OP_SLL  = 4'd2,
      ALU_OP_SLT  = 4'd3,
      ALU_OP_SLTU = 4'd4,
      ALU_OP_XOR  = 4'd5,
      ALU_OP_SRL  = 4'd6,
      ALU_OP_SRA  = 4'd7,
      ALU_OP_OR   = 4'd8,
      ALU_OP_AND  = 4'd9
   } alu_control_t;

endpackage

// File: rtl/alu_decode_stage.sv
// One-entry registered decode stage for RV32I integer ALU ops (R/I-type, LUI, AUIPC),
// with a saturating counter of captured illegal instructions.
module alu_decode_stage
   import alu_types_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [31:0]        instr,
   input  logic [31:0]        pc,
   output logic               in_ready,
   output logic               out_valid,
   input  logic               out_ready,
   input  logic               flush,
   output alu_control_t       alu_control,
   output logic [4:0]         rs1,
   output logic [4:0]         rs2,
   output logic [4:0]         rd,
   output logic               a_sel,
   output logic               b_sel,
   output logic [31:0]        imm,
   output logic [31:0]        pc_out,
   output logic               reg_write,
   output logic               illegal,
   output logic [CNT_W-1:0]   illegal_count
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] F7_STD   = 7'b0000000;
   localparam logic [6:0] F7_ALT   = 7'b0100000;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [6:0]   opcode;
   logic [2:0]   funct3;
   logic [6:0]   funct7;
   logic         capture;

   alu_control_t d_alu;
   logic [4:0]   d_rs1;
   logic [4:0]   d_rs2;
   logic [4:0]   d_rd;
   logic         d_a_sel;
   logic         d_b_sel;
   logic [31:0]  d_imm;
   logic         d_illegal;
   logic         d_reg_write;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign funct7   = instr[31:25];
   assign in_ready = !out_valid || out_ready;
   assign capture  = in_valid && in_ready;

   // alt selects the funct7=0100000 variant (SUB / SRA) where one exists
   function automatic alu_control_t base_op(input logic [2:0] f3, input logic alt);
      alu_control_t op;
      case (f3)
         3'b000:  op = alt ? ALU_OP_SUB : ALU_OP_ADD;
         3'b001:  op = ALU_OP_SLL;
         3'b010:  op = ALU_OP_SLT;
         3'b011:  op = ALU_OP_SLTU;
         3'b100:  op = ALU_OP_XOR;
         3'b101:  op = alt ? ALU_OP_SRA : ALU_OP_SRL;
         3'b110:  op = ALU_OP_OR;
         default: op = ALU_OP_AND;
      endcase
      return op;
   endfunction

   always_comb begin
      d_alu     = ALU_OP_ADD;
      d_rs1     = instr[19:15];
      d_rs2     = 5'd0;
      d_rd      = instr[11:7];
      d_a_sel   = 1'b0;
      d_b_sel   = 1'b0;
      d_imm     = 32'd0;
      d_illegal = 1'b0;

      case (opcode)
         OP_R: begin
            d_rs2 = instr[24:20];
            if (funct7 == F7_ALT)
               d_illegal = !((funct3 == 3'b000) || (funct3 == 3'b101));
            else if (funct7 != F7_STD)
               d_illegal = 1'b1;
            d_alu = base_op(funct3, funct7 == F7_ALT);
         end
         OP_I: begin
            d_b_sel = 1'b1;
            if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
               d_imm = {27'b0, instr[24:20]};
               if (funct7 == F7_ALT)
                  d_illegal = (funct3 == 3'b001);
               else if (funct7 != F7_STD)
                  d_illegal = 1'b1;
               d_alu = base_op(funct3, funct7 == F7_ALT);
            end else begin
               // no ADDI/SUBI distinction: funct3 000 is always ADD here
               d_imm = {{20{instr[31]}}, instr[31:20]};
               d_alu = base_op(funct3, 1'b0);
            end
         end
         OP_LUI: begin
            d_rs1   = 5'd0;
            d_b_sel = 1'b1;
            d_imm   = {instr[31:12], 12'b0};
         end
         OP_AUIPC: begin
            d_a_sel = 1'b1;
            d_b_sel = 1'b1;
            d_imm   = {instr[31:12], 12'b0};
         end
         default: d_illegal = 1'b1;
      endcase

      if (d_illegal) begin
         d_alu   = ALU_OP_ADD;
         d_imm   = 32'd0;
         d_a_sel = 1'b0;
         d_b_sel = 1'b0;
      end
      d_reg_write = !d_illegal && (d_rd != 5'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         alu_control   <= ALU_OP_ADD;
         rs1           <= 5'd0;
         rs2           <= 5'd0;
         rd            <= 5'd0;
         a_sel         <= 1'b0;
         b_sel         <= 1'b0;
         imm           <= 32'd0;
         pc_out        <= 32'd0;
         reg_write     <= 1'b0;
         illegal       <= 1'b0;
         illegal_count <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (capture) begin
         out_valid   <= 1'b1;
         alu_control <= d_alu;
         rs1         <= d_rs1;
         rs2         <= d_rs2;
         rd          <= d_rd;
         a_sel       <= d_a_sel;
         b_sel       <= d_b_sel;
         imm         <= d_imm;
         pc_out      <= pc;
         reg_write   <= d_reg_write;
         illegal     <= d_illegal;
         if (d_illegal && (illegal_count != '1))
            illegal_count <= illegal_count + CNT_ONE;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage; a second CNT_W=4 instance checks counter saturation.
module tb_alu_decode_stage;
   import alu_types_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [31:0]  instr;
   logic [31:0]  pc;
   logic         out_ready;
   logic         flush;

   logic         in_ready, out_valid, a_sel, b_sel, reg_write, illegal;
   alu_control_t alu_control;
   logic [4:0]   rs1, rs2, rd;
   logic [31:0]  imm, pc_out;
   logic [15:0]  illegal_count;

   logic         in_ready_4, out_valid_4, a_sel_4, b_sel_4, reg_write_4, illegal_4;
   alu_control_t alu_control_4;
   logic [4:0]   rs1_4, rs2_4, rd_4;
   logic [31:0]  imm_4, pc_out_4;
   logic [3:0]   illegal_count_4;

   alu_decode_stage u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .pc(pc),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
      .alu_control(alu_control), .rs1(rs1), .rs2(rs2), .rd(rd), .a_sel(a_sel), .b_sel(b_sel),
      .imm(imm), .pc_out(pc_out), .reg_write(reg_write), .illegal(illegal),
      .illegal_count(illegal_count)
   );

   alu_decode_stage #(.CNT_W(4)) u_dut_4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .pc(pc),
      .in_ready(in_ready_4), .out_valid(out_valid_4), .out_ready(out_ready), .flush(flush),
      .alu_control(alu_control_4), .rs1(rs1_4), .rs2(rs2_4), .rd(rd_4), .a_sel(a_sel_4),
      .b_sel(b_sel_4), .imm(imm_4), .pc_out(pc_out_4), .reg_write(reg_write_4),
      .illegal(illegal_4), .illegal_count(illegal_count_4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]  instr;
      logic [31:0]  pc;
      alu_control_t alu;
      logic [4:0]   rs1;
      logic [4:0]   rs2;
      logic [4:0]   rd;
      logic         a_sel;
      logic         b_sel;
      logic [31:0]  imm;
      logic         reg_write;
      logic         illegal;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          errors = 0;
   int          checks = 0;
   int          exp_cnt = 0;
   logic [31:0] next_pc = 32'h0000_1000;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] i, input alu_control_t a,
                               input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                               input logic as, input logic bs, input logic [31:0] im,
                               input logic rw, input logic il);
      exp_t e;
      e.instr = i; e.pc = 32'd0; e.alu = a; e.rs1 = r1; e.rs2 = r2; e.rd = d;
      e.a_sel = as; e.b_sel = bs; e.imm = im; e.reg_write = rw; e.illegal = il;
      return e;
   endfunction

   function automatic exp_t bad(input logic [31:0] i);
      return mk(i, ALU_OP_ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
   endfunction

   // Every completed downstream transfer is matched against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("pc_out", pc_out, mon_e.pc);
            chk("illegal", 32'(illegal), 32'(mon_e.illegal));
            chk("reg_write", 32'(reg_write), 32'(mon_e.reg_write));
            chk("alu_control", 32'(alu_control), 32'(mon_e.alu));
            chk("imm", imm, mon_e.imm);
            if (!mon_e.illegal) begin
               chk("rs1", 32'(rs1), 32'(mon_e.rs1));
               chk("rs2", 32'(rs2), 32'(mon_e.rs2));
               chk("rd", 32'(rd), 32'(mon_e.rd));
               chk("a_sel", 32'(a_sel), 32'(mon_e.a_sel));
               chk("b_sel", 32'(b_sel), 32'(mon_e.b_sel));
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the instruction was accepted.
   task automatic issue(input exp_t e_in);
      exp_t e;
      int   n;
      e = e_in;
      e.pc = next_pc;
      next_pc = next_pc + 32'd4;
      in_valid = 1'b1;
      instr = e.instr;
      pc = e.pc;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("issue_timeout", 32'd0, 32'd1);
      end else begin
         sb.push_back(e);
         if (e.illegal) exp_cnt++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", 32'(sb.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic chk_counts(input string tag);
      @(negedge clk);
      chk({tag, "_cnt16"}, 32'(illegal_count), 32'(exp_cnt));
      chk({tag, "_cnt4"}, 32'(illegal_count_4), (exp_cnt > 15) ? 32'd15 : 32'(exp_cnt));
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; instr = 32'd0; pc = 32'd0; out_ready = 1'b1; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_alu", 32'(alu_control), 32'(ALU_OP_ADD));
      chk("rst_imm", imm, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_count", 32'(illegal_count), 32'd0);
      @(posedge clk); #1;

      // Back-to-back legal and illegal decodes
      issue(mk(32'h002081B3, ALU_OP_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0));
      issue(mk(32'h402081B3, ALU_OP_SUB, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0));
      issue(mk(32'h4020D1B3, ALU_OP_SRA, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0));
      issue(mk(32'h40335293, ALU_OP_SRA, 5'd6, 5'd0, 5'd5, 1'b0, 1'b1, 32'd3, 1'b1, 1'b0));
      issue(mk(32'hFFF00093, ALU_OP_ADD, 5'd0, 5'd0, 5'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0));
      issue(mk(32'h12345137, ALU_OP_ADD, 5'd0, 5'd0, 5'd2, 1'b0, 1'b1, 32'h1234_5000, 1'b1, 1'b0));
      issue(mk(32'h00001017, ALU_OP_ADD, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0000_1000, 1'b0, 1'b0));
      issue(bad(32'h00000000));
      issue(mk(32'h403081B3, ALU_OP_SUB, 5'd1, 5'd3, 5'd3, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0));
      issue(bad(32'h40209193));
      issue(bad(32'h022081B3));
      drain();
      chk_counts("decode");

      // Downstream stall: first held, second blocked until out_ready rises
      out_ready = 1'b0;
      issue(mk(32'h002081B3, ALU_OP_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0));
      in_valid = 1'b1;
      instr = 32'h402081B3;
      pc = 32'hDEAD_0000;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_pc_held", pc_out, next_pc - 32'd4);
         chk("stall_alu_held", 32'(alu_control), 32'(ALU_OP_ADD));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      issue(mk(32'h402081B3, ALU_OP_SUB, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0));
      drain();
      @(negedge clk);
      chk("stall_no_dup", 32'(out_valid), 32'd0);
      @(posedge clk); #1;

      // Flush discards the held entry, then drops an incoming illegal instruction
      out_ready = 1'b0;
      issue(mk(32'h002081B3, ALU_OP_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0));
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      void'(sb.pop_back());
      @(negedge clk);
      chk("flush_held_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      flush = 1'b1; in_valid = 1'b1; instr = 32'h00000000;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_in_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk_counts("flush");

      // Reset while an illegal entry is held
      issue(bad(32'h00000000));
      chk_counts("pre_rst");
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      exp_cnt = 0;
      @(negedge clk);
      chk("rst_mid_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      chk_counts("rst_mid");

      // Saturation of the 4-bit counter
      out_ready = 1'b1;
      for (int k = 0; k < 17; k++) issue(bad(32'h0000007F));
      drain();
      chk_counts("sat");
      repeat (3) @(posedge clk);
      #1;
      chk_counts("sat_hold");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
